// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and helpers for the register-file
//                write-back arbiter (default widths, x0 address, counter
//                width, round-robin wrap helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default register address and data widths
    localparam int c_aw_default = 5;
    localparam int c_dw_default = 32;

    // Register 0 is hard-wired; writes to it are consumed but never issued
    localparam int c_x0_addr    = 0;

    // Width of the committed-write counter
    localparam int c_wr_count_w = 16;

    // Returns (base + off) mod n, assuming base < n and off <= n
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant. The search begins at
//                'pointer' and wraps modulo N; the first valid requester
//                found receives a one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant
);

    logic w_found;

    // Scan requesters in priority order pointer, pointer+1, ... (mod N)
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && valid[i] && (i == rr_wrap(int'(pointer), k, N))) begin
                    grant[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin arbiter collecting register-file write-backs
//                from NREQ requesters. A transfer in cycle t is staged and
//                issued as a single-cycle RegWrite in t+1. Writes to x0 are
//                consumed silently. wr_count tracks committed writes.
//                Optional macro REGFILE_WB_BYPASS_EN adds two combinational
//                read-port bypass paths from the staged write.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = c_aw_default,
    parameter int DW   = c_dw_default
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    hold,
    output logic                    RegWrite,
    output logic [AW-1:0]           write_reg,
    output logic [DW-1:0]           write_data,
    output logic [c_wr_count_w-1:0] wr_count
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]           rd_addr_1,
    input  logic [AW-1:0]           rd_addr_2,
    input  logic [DW-1:0]           rf_data_1,
    input  logic [DW-1:0]           rf_data_2,
    output logic [DW-1:0]           fwd_data_1,
    output logic [DW-1:0]           fwd_data_2
`endif
);

    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [c_ptr_w-1:0]      r_ptr;
    logic                    r_reg_write;
    logic [AW-1:0]           r_write_reg;
    logic [DW-1:0]           r_write_data;
    logic [c_wr_count_w-1:0] r_wr_count;

    logic [NREQ-1:0]         w_grant;
    logic                    w_xfer;
    logic                    w_wr_en;
    logic [AW-1:0]           w_sel_addr;
    logic [DW-1:0]           w_sel_data;
    logic [c_ptr_w-1:0]      w_ptr_next;

    rr_arbiter #(
        .N  (NREQ),
        .PW (c_ptr_w)
    ) u_rr_arbiter (
        .valid   (req_valid),
        .pointer (r_ptr),
        .grant   (w_grant)
    );

    // Grants are suppressed while frozen or held in reset
    assign req_ready = (rst_n && !hold) ? w_grant : '0;

    // Select the granted requester's payload and the next priority pointer
    always_comb begin
        w_xfer     = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_ptr_next = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                w_xfer     = 1'b1;
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
                w_ptr_next = c_ptr_w'(rr_wrap(i, 1, NREQ));
            end
        end
    end

    // A transfer to x0 is accepted but never reaches the register file
    assign w_wr_en = w_xfer && (w_sel_addr != AW'(c_x0_addr));

    // Priority pointer advances past the requester just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Stage the write for one-cycle issue; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_reg_write <= w_wr_en;
            if (w_wr_en) begin
                r_write_reg  <= w_sel_addr;
                r_write_data <= w_sel_data;
            end
        end
    end

    // Count committed writes; it advances together with the RegWrite pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count <= '0;
        end else if (w_wr_en) begin
            r_wr_count <= r_wr_count + 1'b1;
        end
    end

    assign RegWrite   = r_reg_write;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign wr_count   = r_wr_count;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the issuing write to read port 1 when addresses match
    always_comb begin
        fwd_data_1 = rf_data_1;
        if (r_reg_write && (r_write_reg == rd_addr_1) && (rd_addr_1 != AW'(c_x0_addr))) begin
            fwd_data_1 = r_write_data;
        end
    end

    // Forward the issuing write to read port 2 when addresses match
    always_comb begin
        fwd_data_2 = rf_data_2;
        if (r_reg_write && (r_write_reg == rd_addr_2) && (rd_addr_2 != AW'(c_x0_addr))) begin
            fwd_data_2 = r_write_data;
        end
    end
`endif

endmodule : regfile_wb_arbiter
`default_nettype wire
